div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the EX stage. It services the DIV and DIVU instructions that the decoder tags with a HI/LO write (both write enables set). It takes the two register operands and returns {remainder, quotient} for the HI/LO register file. While it works it holds the pipeline through a stall request.

---
 rtl/div_unit_if.sv | 21 ++
 rtl/div_unit.sv | 83 ++++++++
 tb/tb_div_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// div_unit_if: divide request/response bundle between the EX stage and div_unit.
// Ports: start, signed_div, annul, opdata1, opdata2 (EX -> divider);
//        result, ready, stall_req (divider -> EX / hazard unit).
interface div_unit_if;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;
  modport master (
    output start, signed_div, annul, opdata1, opdata2,
    input  result, ready, stall_req
  );
  modport slave (
    input  start, signed_div, annul, opdata1, opdata2,
    output result, ready, stall_req
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: 32-cycle restoring divider for DIV/DIVU, result = {remainder, quotient}.
// Ports: clk, resetn (sync, active-low); bus (div_unit_if.slave):
//   start/signed_div/annul/opdata1/opdata2 in, result[63:0]/ready/stall_req out.
module div_unit (
  input logic      clk,
  input logic      resetn,
  div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIV_ZERO, ON, END} state_t;
  state_t      state;
  logic [4:0]  count;
  logic [63:0] w;
  logic [31:0] dmag;
  logic [31:0] dvd;
  logic        neg_q;
  logic        neg_r;
  logic [63:0] result;
  logic        ready;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [64:0] sh;
  logic        ok;
  logic [31:0] diff;
  logic [63:0] w_nxt;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  always_comb begin
    a_mag = (bus.signed_div && bus.opdata1[31]) ? -bus.opdata1 : bus.opdata1;
    b_mag = (bus.signed_div && bus.opdata2[31]) ? -bus.opdata2 : bus.opdata2;
    sh    = {w, 1'b0};
    // sh[64] set means the partial remainder already exceeds any 32-bit divisor
    ok    = sh[64] || (sh[63:32] >= dmag);
    diff  = sh[63:32] - dmag;
    w_nxt = ok ? {diff, sh[31:1], 1'b1} : sh[63:0];
    q_fix = neg_q ? -w_nxt[31:0] : w_nxt[31:0];
    r_fix = neg_r ? -w_nxt[63:32] : w_nxt[63:32];
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      count  <= '0;
      ready  <= 1'b0;
      result <= '0;
    end else if (bus.annul) begin
      state <= IDLE;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          dvd   <= bus.opdata1;
          dmag  <= b_mag;
          w     <= {32'h0, a_mag};
          neg_q <= bus.signed_div && (bus.opdata1[31] ^ bus.opdata2[31]);
          neg_r <= bus.signed_div && bus.opdata1[31];
          count <= '0;
          state <= (bus.opdata2 == 32'h0) ? DIV_ZERO : ON;
        end
        DIV_ZERO: begin
          result <= {dvd, 32'hFFFF_FFFF};
          ready  <= 1'b1;
          state  <= END;
        end
        ON: begin
          w     <= w_nxt;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            result <= {r_fix, q_fix};
            ready  <= 1'b1;
            state  <= END;
          end
        end
        END: if (!bus.start) begin
          state <= IDLE;
          ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.result    = result;
  assign bus.ready     = ready;
  assign bus.stall_req = bus.start && !ready && !bus.annul;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven, scoreboarded bench for div_unit.
module tb_div_unit;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  div_unit_if bus ();
  div_unit dut (.clk(clk), .resetn(resetn), .bus(bus));
  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
    int          lat;
    string       name;
  } vec_t;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  vec_t        v[12];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wait_ready(input string name, input int k0, input int lat);
    int          k = k0;
    bit          seen = 0;
    logic [63:0] e = '0;
    while (k <= lat + 5) begin
      @(negedge clk);
      if (bus.ready) begin
        seen = 1;
        break;
      end
      chk({name, " stall"}, 64'(bus.stall_req), 64'd1);
      if (k == k0 + 1) begin
        bus.opdata1 = $urandom;
        bus.opdata2 = $urandom;
        bus.signed_div = ~bus.signed_div;
      end
      k++;
    end
    if (exp_q.size() != 0) e = exp_q.pop_front();
    if (!seen) begin
      chk({name, " ready timeout"}, 64'd0, 64'd1);
      bus.start = 1'b0;
      return;
    end
    chk({name, " latency"}, 64'(k), 64'(lat));
    chk({name, " result"}, bus.result, e);
    chk({name, " stall low"}, 64'(bus.stall_req), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk({name, " END hold ready"}, 64'(bus.ready), 64'd1);
    @(negedge clk);
    chk({name, " drop ready"}, 64'(bus.ready), 64'd0);
    chk({name, " drop result held"}, bus.result, e);
  endtask
  task automatic run(input vec_t x);
    exp_q.push_back(x.r);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.signed_div = x.s;
    bus.opdata1 = x.a;
    bus.opdata2 = x.b;
    wait_ready(x.name, 0, x.lat);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    v[0]  = '{1'b0, 32'd100,       32'd7,         {32'd2,         32'd14},        33, "divu_100_7"};
    v[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2"};
    v[2]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, {32'd1,         32'hFFFF_FFFD}, 33, "div_7_m2"};
    v[3]  = '{1'b0, 32'h0000_1234, 32'd0,         {32'h0000_1234, 32'hFFFF_FFFF}, 2,  "divu_by_zero"};
    v[4]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0,         32'h8000_0000}, 33, "div_overflow"};
    v[5]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0},         33, "divu_8000_ffff"};
    v[6]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14},        33, "div_m100_m7"};
    v[7]  = '{1'b0, 32'hFFFF_FFFF, 32'd16,        {32'hF,         32'h0FFF_FFFF}, 33, "divu_max_16"};
    v[8]  = '{1'b1, 32'hFFFF_FFF0, 32'd0,         {32'hFFFF_FFF0, 32'hFFFF_FFFF}, 2,  "div_by_zero"};
    v[9]  = '{1'b1, 32'd0,         32'd5,         {32'h0,         32'h0},         33, "div_0_5"};
    v[10] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         {32'h0,         32'hFFFF_FFFF}, 33, "divu_max_1"};
    v[11] = '{1'b1, 32'h7FFF_FFFF, 32'd16,        {32'hF,         32'h07FF_FFFF}, 33, "div_max_16"};
    bus.start = 1'b0;
    bus.signed_div = 1'b0;
    bus.annul = 1'b0;
    bus.opdata1 = '0;
    bus.opdata2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 64'(bus.ready), 64'd0);
    chk("reset result", bus.result, 64'd0);
    chk("reset stall", 64'(bus.stall_req), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    foreach (v[i]) run(v[i]);
    exp_q.push_back({32'd0, 32'd3});
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd1000;
    bus.opdata2 = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    @(negedge clk);
    chk("annul stall", 64'(bus.stall_req), 64'd0);
    chk("annul ready", 64'(bus.ready), 64'd0);
    @(posedge clk); #1;
    bus.annul = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd9;
    bus.opdata2 = 32'd3;
    wait_ready("annul_then_divu_9_3", 11, 44);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd12345;
    bus.opdata2 = 32'd7;
    repeat (20) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midop reset ready", 64'(bus.ready), 64'd0);
    chk("midop reset result", bus.result, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    bus.start = 1'b0;
    run(v[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
